// File: rtl/vfalu_pkg.sv
// Shared FSPU writeback definitions: default geometry, writeback port select,
// and the flat entry layout {data, dst_gpr, iid, preg} from MSB to LSB.
package vfalu_pkg;

   localparam int WB_DEPTH  = 2;
   localparam int WB_IID_W  = 7;
   localparam int WB_PREG_W = 7;
   localparam int WB_DATA_W = 64;

   typedef enum logic [1:0] {
      WB_SEL_NONE = 2'd0,
      WB_SEL_FPR  = 2'd1,
      WB_SEL_GPR  = 2'd2
   } wb_sel_e;

   function automatic int wb_entry_w(input int iid_w, input int preg_w);
      return WB_DATA_W + 1 + iid_w + preg_w;
   endfunction

   function automatic int wb_iid_lsb(input int preg_w);
      return preg_w;
   endfunction

   function automatic int wb_dst_pos(input int iid_w, input int preg_w);
      return iid_w + preg_w;
   endfunction

   function automatic int wb_data_lsb(input int iid_w, input int preg_w);
      return iid_w + preg_w + 1;
   endfunction

endpackage

// File: rtl/ct_fspu_wb_buf_if.sv
// EX1-push / writeback-pop bundle of the FSPU writeback buffer.
// The slave modport is the buffer's view, master is the surrounding pipeline.
interface ct_fspu_wb_buf_if
   import vfalu_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int IID_W  = WB_IID_W,
   parameter int PREG_W = WB_PREG_W
) ();

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                 ex1_vld;
   logic                 ex1_rdy;
   logic                 ex1_dst_gpr;
   logic [63:0]          ex1_result;
   logic [63:0]          result_fmfvr;
   logic [IID_W-1:0]     ex1_iid;
   logic [PREG_W-1:0]    ex1_preg;
   logic                 rtu_flush;
   logic                 wb_fpr_vld;
   logic                 wb_gpr_vld;
   logic                 wb_rdy;
   logic [63:0]          wb_data;
   logic [IID_W-1:0]     wb_iid;
   logic [PREG_W-1:0]    wb_preg;
   logic [CNT_W-1:0]     wb_cnt;

   modport slave (
      input  ex1_vld, ex1_dst_gpr, ex1_result, result_fmfvr, ex1_iid, ex1_preg,
      input  rtu_flush, wb_rdy,
      output ex1_rdy, wb_fpr_vld, wb_gpr_vld, wb_data, wb_iid, wb_preg, wb_cnt
   );

   modport master (
      output ex1_vld, ex1_dst_gpr, ex1_result, result_fmfvr, ex1_iid, ex1_preg,
      output rtu_flush, wb_rdy,
      input  ex1_rdy, wb_fpr_vld, wb_gpr_vld, wb_data, wb_iid, wb_preg, wb_cnt
   );

endinterface

// File: rtl/ct_fspu_wb_entry.sv
// One writeback buffer slot: a flat entry register loaded on write enable.
module ct_fspu_wb_entry #(
   parameter int W = 79
) (
   input  logic         clk_i,
   input  logic         rst_b_i,
   input  logic         we_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] ent_q;
   logic [W-1:0] ent_d;

   // Hold the slot unless it is the current write target.
   always_comb begin
      ent_d = ent_q;
      if (we_i) begin
         ent_d = d_i;
      end else begin
         ent_d = ent_q;
      end
   end

   // Slot storage.
   always_ff @(posedge clk_i or negedge rst_b_i) begin
      if (!rst_b_i) begin
         ent_q <= {W{1'b0}};
      end else begin
         ent_q <= ent_d;
      end
   end

   assign q_o = ent_q;

endmodule

// File: rtl/ct_fspu_wb_buf.sv
// FSPU writeback buffer: small FIFO between EX1 and the FPR/GPR writeback
// ports; the head entry is presented one cycle after its push.
module ct_fspu_wb_buf
   import vfalu_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int IID_W  = WB_IID_W,
   parameter int PREG_W = WB_PREG_W
) (
   input  logic               forever_cpuclk,
   input  logic               cpurst_b,
   ct_fspu_wb_buf_if.slave    bus
);

   localparam int PTR_W    = $clog2(DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int ENT_W    = wb_entry_w(IID_W, PREG_W);
   localparam int IID_LSB  = wb_iid_lsb(PREG_W);
   localparam int DST_POS  = wb_dst_pos(IID_W, PREG_W);
   localparam int DATA_LSB = wb_data_lsb(IID_W, PREG_W);

   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   logic             not_full_s;
   logic             head_vld_s;
   logic             push_s;
   logic             pop_s;
   logic [DEPTH-1:0] we_s;
   logic [ENT_W-1:0] wr_ent_s;
   logic [ENT_W-1:0] head_s;
   logic [ENT_W-1:0] ent_q [DEPTH];
   wb_sel_e          sel_s;

   // Readiness comes only from the registered count, never from wb_rdy.
   assign not_full_s = (cnt_q < CNT_W'(DEPTH));
   assign head_vld_s = (cnt_q != {CNT_W{1'b0}});
   assign head_s     = ent_q[rd_ptr_q];

   // Handshake qualification; a flush cancels both sides of the cycle.
   always_comb begin
      push_s   = bus.ex1_vld && not_full_s && !bus.rtu_flush;
      pop_s    = head_vld_s && bus.wb_rdy && !bus.rtu_flush;
      wr_ent_s = {(bus.ex1_dst_gpr ? bus.result_fmfvr : bus.ex1_result),
                  bus.ex1_dst_gpr, bus.ex1_iid, bus.ex1_preg};
   end

   // One-hot write enable for the slot under the write pointer.
   always_comb begin
      we_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         we_s[i] = push_s && (wr_ptr_q == PTR_W'(i));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      ct_fspu_wb_entry #(
         .W (ENT_W)
      ) u_ent (
         .clk_i   (forever_cpuclk),
         .rst_b_i (cpurst_b),
         .we_i    (we_s[g]),
         .d_i     (wr_ent_s),
         .q_o     (ent_q[g])
      );
   end

   // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (bus.rtu_flush) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         cnt_d    = {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Head presentation; payload is forced to zero whenever nothing is valid.
   always_comb begin
      sel_s          = WB_SEL_NONE;
      bus.ex1_rdy    = not_full_s;
      bus.wb_cnt     = cnt_q;
      bus.wb_fpr_vld = 1'b0;
      bus.wb_gpr_vld = 1'b0;
      bus.wb_data    = 64'd0;
      bus.wb_iid     = {IID_W{1'b0}};
      bus.wb_preg    = {PREG_W{1'b0}};
      if (!head_vld_s) begin
         sel_s = WB_SEL_NONE;
      end else if (head_s[DST_POS]) begin
         sel_s = WB_SEL_GPR;
      end else begin
         sel_s = WB_SEL_FPR;
      end
      case (sel_s)
         WB_SEL_FPR: bus.wb_fpr_vld = 1'b1;
         WB_SEL_GPR: bus.wb_gpr_vld = 1'b1;
         default:    bus.wb_fpr_vld = 1'b0;
      endcase
      if (sel_s != WB_SEL_NONE) begin
         bus.wb_data = head_s[ENT_W-1:DATA_LSB];
         bus.wb_iid  = head_s[DST_POS-1:IID_LSB];
         bus.wb_preg = head_s[IID_LSB-1:0];
      end else begin
         bus.wb_data = 64'd0;
         bus.wb_iid  = {IID_W{1'b0}};
         bus.wb_preg = {PREG_W{1'b0}};
      end
   end

endmodule

// File: tb/tb_ct_fspu_wb_buf.sv
// Bench for ct_fspu_wb_buf: directed scenarios plus random traffic, all
// compared against a queue-based model of the writeback FIFO.
module tb_ct_fspu_wb_buf;

   localparam int DEPTH  = 2;
   localparam int IID_W  = 7;
   localparam int PREG_W = 7;

   typedef struct {
      logic [63:0]       data;
      logic              dst;
      logic [IID_W-1:0]  iid;
      logic [PREG_W-1:0] preg;
   } ent_t;

   logic clk = 1'b0;
   logic rst_b;
   int   n_checks = 0;
   int   n_errors = 0;
   ent_t mq[$];

   ct_fspu_wb_buf_if #(.DEPTH(DEPTH), .IID_W(IID_W), .PREG_W(PREG_W)) bus ();

   ct_fspu_wb_buf #(
      .DEPTH  (DEPTH),
      .IID_W  (IID_W),
      .PREG_W (PREG_W)
   ) dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_b),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Expected outputs follow directly from the queue contents.
   task automatic check_model();
      int n;
      n = mq.size();
      check_val("ex1_rdy", 64'(bus.ex1_rdy), 64'(n < DEPTH));
      check_val("wb_cnt", 64'(bus.wb_cnt), 64'(n));
      if (n > 0) begin
         check_val("wb_fpr_vld", 64'(bus.wb_fpr_vld), 64'(!mq[0].dst));
         check_val("wb_gpr_vld", 64'(bus.wb_gpr_vld), 64'(mq[0].dst));
         check_val("wb_data", bus.wb_data, mq[0].data);
         check_val("wb_iid", 64'(bus.wb_iid), 64'(mq[0].iid));
         check_val("wb_preg", 64'(bus.wb_preg), 64'(mq[0].preg));
      end else begin
         check_val("wb_fpr_vld", 64'(bus.wb_fpr_vld), 64'd0);
         check_val("wb_gpr_vld", 64'(bus.wb_gpr_vld), 64'd0);
         check_val("wb_data", bus.wb_data, 64'd0);
         check_val("wb_iid", 64'(bus.wb_iid), 64'd0);
         check_val("wb_preg", 64'(bus.wb_preg), 64'd0);
      end
   endtask

   task automatic cycle(input logic vld, input logic dst, input logic [63:0] res,
                        input logic [63:0] fm, input logic [IID_W-1:0] iid,
                        input logic [PREG_W-1:0] preg, input logic flush, input logic rdy);
      bit   push;
      bit   pop;
      ent_t e;
      check_model();
      bus.ex1_vld      = vld;
      bus.ex1_dst_gpr  = dst;
      bus.ex1_result   = res;
      bus.result_fmfvr = fm;
      bus.ex1_iid      = iid;
      bus.ex1_preg     = preg;
      bus.rtu_flush    = flush;
      bus.wb_rdy       = rdy;
      push   = vld && (mq.size() < DEPTH) && !flush;
      pop    = (mq.size() > 0) && rdy && !flush;
      e.data = dst ? fm : res;
      e.dst  = dst;
      e.iid  = iid;
      e.preg = preg;
      @(posedge clk);
      if (flush) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      cycle(1'b0, 1'b0, 64'd0, 64'd0, 7'd0, 7'd0, 1'b0, rdy);
   endtask

   initial begin
      bus.ex1_vld      = 1'b0;
      bus.ex1_dst_gpr  = 1'b0;
      bus.ex1_result   = 64'd0;
      bus.result_fmfvr = 64'd0;
      bus.ex1_iid      = 7'd0;
      bus.ex1_preg     = 7'd0;
      bus.rtu_flush    = 1'b0;
      bus.wb_rdy       = 1'b0;
      rst_b            = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_ex1_rdy", 64'(bus.ex1_rdy), 64'd1);
      check_val("rst_cnt", 64'(bus.wb_cnt), 64'd0);
      check_val("rst_fpr_vld", 64'(bus.wb_fpr_vld), 64'd0);
      check_val("rst_data", bus.wb_data, 64'd0);
      rst_b = 1'b1;
      @(negedge clk);

      // single FPR result, popped immediately
      cycle(1'b1, 1'b0, 64'h0000_0000_3F80_0000, 64'h1111, 7'd5, 7'd11, 1'b0, 1'b1);
      check_val("t1_fpr_vld", 64'(bus.wb_fpr_vld), 64'd1);
      check_val("t1_data", bus.wb_data, 64'h0000_0000_3F80_0000);
      check_val("t1_iid", 64'(bus.wb_iid), 64'd5);
      idle(1'b1);
      check_val("t1_cnt", 64'(bus.wb_cnt), 64'd0);

      // single GPR result
      cycle(1'b1, 1'b1, 64'h1234, 64'hFFFF_FFFF_BF80_0000, 7'd6, 7'd12, 1'b0, 1'b1);
      check_val("t2_gpr_vld", 64'(bus.wb_gpr_vld), 64'd1);
      check_val("t2_fpr_vld", 64'(bus.wb_fpr_vld), 64'd0);
      check_val("t2_data", bus.wb_data, 64'hFFFF_FFFF_BF80_0000);
      idle(1'b1);

      // backpressure fill, full+pop without push, then drain
      cycle(1'b1, 1'b0, 64'hA1, 64'd0, 7'd1, 7'd21, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 64'd0, 64'hA2, 7'd2, 7'd22, 1'b0, 1'b0);
      check_val("t3_full_rdy", 64'(bus.ex1_rdy), 64'd0);
      cycle(1'b1, 1'b0, 64'hA3, 64'd0, 7'd3, 7'd23, 1'b0, 1'b0);
      check_val("t3_hold_iid", 64'(bus.wb_iid), 64'd1);
      check_val("t3_hold_cnt", 64'(bus.wb_cnt), 64'd2);
      cycle(1'b1, 1'b0, 64'hA3, 64'd0, 7'd3, 7'd23, 1'b0, 1'b1);
      check_val("t4_cnt", 64'(bus.wb_cnt), 64'd1);
      check_val("t4_iid", 64'(bus.wb_iid), 64'd2);
      cycle(1'b1, 1'b0, 64'hA3, 64'd0, 7'd3, 7'd23, 1'b0, 1'b1);
      check_val("t4_iid3", 64'(bus.wb_iid), 64'd3);
      idle(1'b1);

      // flush with two held entries and a concurrent push
      cycle(1'b1, 1'b0, 64'hB0, 64'd0, 7'd20, 7'd1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 64'hB1, 64'd0, 7'd21, 7'd2, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 64'hB2, 64'd0, 7'd22, 7'd3, 1'b1, 1'b1);
      check_val("t5_cnt", 64'(bus.wb_cnt), 64'd0);
      check_val("t5_vld", 64'({bus.wb_fpr_vld, bus.wb_gpr_vld}), 64'd0);
      idle(1'b1);

      // asynchronous reset with an entry pending
      cycle(1'b1, 1'b0, 64'hC0, 64'd0, 7'd30, 7'd4, 1'b0, 1'b0);
      #2 rst_b = 1'b0;
      #1;
      check_val("t6_vld", 64'({bus.wb_fpr_vld, bus.wb_gpr_vld}), 64'd0);
      check_val("t6_cnt", 64'(bus.wb_cnt), 64'd0);
      check_val("t6_rdy", 64'(bus.ex1_rdy), 64'd1);
      mq.delete();
      @(negedge clk);
      rst_b = 1'b1;
      cycle(1'b1, 1'b0, 64'hC9, 64'd0, 7'd9, 7'd5, 1'b0, 1'b0);
      check_val("t6_iid9", 64'(bus.wb_iid), 64'd9);
      check_val("t6_data9", bus.wb_data, 64'hC9);
      idle(1'b1);

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               {$urandom(), $urandom()}, {$urandom(), $urandom()},
               7'($urandom()), 7'($urandom()),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
      end
      check_model();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ct_fspu_wb_buf.md
CT_FSPU_WB_BUF -- requirements
Module: ct_fspu_wb_buf

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH, default 2: number of buffer entries; legal values are powers of two and at least 2.
REQ-002 The block SHALL have parameter IID_W, default 7: instruction-ID width.
REQ-003 The block SHALL have parameter PREG_W, default 7: physical-register tag width.

Ports (name, direction, width, meaning):
REQ-004 forever_cpuclk, in, 1: sole clock. cpurst_b, in, 1: reset, asynchronous, active-low.
REQ-005 ex1_vld, in, 1: EX1 has a valid FSPU result this cycle.
REQ-006 ex1_rdy, out, 1: buffer can accept an entry this cycle.
REQ-007 ex1_dst_gpr, in, 1: 1 selects a GPR destination (FMV.X.W); 0 selects an FPR destination.
REQ-008 ex1_result, in, 64: FPR-bound FSPU result. result_fmfvr, in, 64: GPR-bound FSPU result.
REQ-009 ex1_iid, in, IID_W: instruction ID. ex1_preg, in, PREG_W: destination physical register tag.
REQ-010 rtu_flush, in, 1: pipeline flush.
REQ-011 wb_fpr_vld, out, 1 and wb_gpr_vld, out, 1: head entry is presented to the FPR or the GPR writeback port respectively.
REQ-012 wb_rdy, in, 1: writeback accepts the head entry.
REQ-013 wb_data, out, 64: head entry data. wb_iid, out, IID_W. wb_preg, out, PREG_W.
REQ-014 wb_cnt, out, log2(DEPTH)+1: current occupancy.

Function
REQ-015 A push SHALL occur when ex1_vld && ex1_rdy && !rtu_flush.
REQ-016 A pushed entry SHALL store: wb_data = ex1_dst_gpr ? result_fmfvr : ex1_result; the dst_gpr bit; ex1_iid; ex1_preg.
REQ-017 ex1_rdy SHALL equal (wb_cnt < DEPTH), driven from registered state only, with no combinational path from wb_rdy.
REQ-018 The head entry SHALL appear on the outputs one cycle after its push (latency 1); there is no input-to-output bypass.
REQ-019 When occupancy is non-zero, wb_fpr_vld SHALL equal !head.dst_gpr and wb_gpr_vld SHALL equal head.dst_gpr; both SHALL be 0 when the buffer is empty.
REQ-020 wb_data, wb_iid and wb_preg SHALL be all-zero while neither valid is asserted.
REQ-021 A pop SHALL occur when (wb_fpr_vld || wb_gpr_vld) && wb_rdy && !rtu_flush.
REQ-022 Entries SHALL drain strictly FIFO.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 Occupancy SHALL update as follows: push only, +1; pop only, -1; push and pop together, unchanged, with the head advancing and the new entry written.
REQ-025 When full, ex1_rdy SHALL be 0 even if a pop occurs in the same cycle.
REQ-026 When empty, a pop SHALL be impossible; a push in the same cycle SHALL appear next cycle.
REQ-027 rtu_flush SHALL, on the next edge, clear occupancy and both pointers to 0; any same-cycle push and pop SHALL be discarded.
REQ-028 Entry payload registers SHALL NOT be required to clear on flush.
REQ-029 wb_rdy held low SHALL hold all outputs stable.

Reset
REQ-030 On cpurst_b low, occupancy and pointers SHALL asynchronously become 0.
REQ-031 During reset, all outputs SHALL be 0 except ex1_rdy, which SHALL be 1 once cpurst_b is low.
REQ-032 Reset asserted mid-operation SHALL drop all entries with no partial writeback.

Structure
REQ-033 DEPTH, IID_W and PREG_W defaults, and the entry-field layout (data, dst_gpr, iid, preg), SHALL be defined in the shared vfalu package.
REQ-034 The block SHALL contain one natural sub-module, ct_fspu_wb_entry: a single entry register with write enable, used DEPTH times. Pointer and count logic SHALL remain at top level.

Verification
REQ-035 Push iid=5, dst_gpr=0, ex1_result=64'h0000_0000_3F80_0000 with wb_rdy=1 -> next cycle wb_fpr_vld=1 and wb_data=64'h3F80_0000; popped that cycle; wb_cnt returns to 0.
REQ-036 Push dst_gpr=1 with result_fmfvr=64'hFFFF_FFFF_BF80_0000 -> wb_gpr_vld=1, wb_fpr_vld=0, wb_data=64'hFFFF_FFFF_BF80_0000.
REQ-037 wb_rdy=0, push iids 1, 2, 3 back-to-back -> iids 1 and 2 accepted, ex1_rdy=0 in the third cycle, iid 3 held; then wb_rdy=1 -> outputs iid 1 then iid 2, then iid 3 is accepted.
REQ-038 Buffer full, wb_rdy=1 and ex1_vld=1 in the same cycle -> one pop, no push, wb_cnt=1.
REQ-039 Two entries held, rtu_flush=1 with ex1_vld=1 -> next cycle wb_cnt=0, no valid asserted, the new entry dropped.
REQ-040 cpurst_b pulsed low with one entry pending -> valids drop immediately and wb_cnt=0; after release, a fresh push of iid 9 emerges correctly, confirming pointer wrap from 0.
